control_unit_p: RTL and testbench

- Parametrised next-generation control unit for the 16-bit MSP430-style datapath.
- Fetches instruction words from program memory through a valid/req handshake and decodes the double-operand and jump formats.
- Sequences PC increment, ALU operation, register-bank write-back and conditional jumps from status flags.
- Detects illegal opcodes and fetch timeouts; drives bank_register, the PC mux and the ALU select.

---
 rtl/control_unit_p.sv | 172 +++++++++++++++++
 tb/tb_control_unit_p.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_p.sv
// Control unit for a 16-bit MSP430-style datapath: fetch handshake, decode of
// double-operand/jump formats, ALU/write-back sequencing and conditional jumps.
module control_unit_p #(
  parameter int unsigned OPW        = 5,
  parameter int unsigned OFFW       = 10,
  parameter int unsigned STALL_MAX  = 15,
  parameter bit          WB_CMP_BIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instruction,
  input  logic            instr_valid,
  input  logic [3:0]      flags,
  output logic            instr_req,
  output logic            en_pc_2,
  output logic            pc_inc,
  output logic            branch_en,
  output logic [OFFW-1:0] pc_offset,
  output logic [3:0]      src_reg,
  output logic [3:0]      dst_reg,
  output logic [3:0]      wr_reg,
  output logic            wr_en,
  output logic [OPW-1:0]  op_code,
  output logic [4:0]      fsm_state,
  output logic            illegal,
  output logic            fault
);

  localparam int unsigned CW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

  typedef enum logic [4:0] {
    S_HALT   = 5'b00000,
    S_FETCH  = 5'b00001,
    S_DECODE = 5'b00010,
    S_EXEC   = 5'b00100,
    S_WB     = 5'b01000,
    S_BRANCH = 5'b10000
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_ir;
  logic [CW-1:0]   r_wait;
  logic            r_fault;
  logic [OPW-1:0]  r_op;
  logic [3:0]      r_src;
  logic [3:0]      r_dst;
  logic [2:0]      r_cond;
  logic [OFFW-1:0] r_off;
  logic            w_wait_last;
  logic            w_taken;
  logic            w_flags_only;
  logic            w_v, w_n, w_z, w_c;

  assign {w_v, w_n, w_z, w_c} = flags;
  assign w_wait_last  = (r_wait == CW'(STALL_MAX - 1));
  assign w_flags_only = !WB_CMP_BIT && ((r_op == OPW'(5)) || (r_op == OPW'(7)));

  always_comb begin
    w_taken = 1'b0;
    unique case (r_cond)
      3'd0: w_taken = !w_z;
      3'd1: w_taken = w_z;
      3'd2: w_taken = !w_c;
      3'd3: w_taken = w_c;
      3'd4: w_taken = w_n;
      3'd5: w_taken = !(w_n ^ w_v);
      3'd6: w_taken = w_n ^ w_v;
      3'd7: w_taken = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        // a valid word on the last allowed wait cycle wins over the timeout
        if (instr_valid)      w_next = S_DECODE;
        else if (w_wait_last) w_next = S_HALT;
      end
      S_DECODE: begin
        if (r_ir[15:14] != 2'b00)       w_next = S_EXEC;
        else if (r_ir[15:13] == 3'b001) w_next = S_BRANCH;
        else                            w_next = S_FETCH;
      end
      S_EXEC:   w_next = w_flags_only ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_wait  <= '0;
      r_fault <= 1'b0;
      r_op    <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cond  <= '0;
      r_off   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_ir   <= instruction;
            r_wait <= '0;
          end else begin
            r_wait <= r_wait + CW'(1);
            if (w_wait_last) r_fault <= 1'b1;
          end
        end
        S_DECODE: begin
          if (r_ir[15:14] != 2'b00) begin
            r_op  <= OPW'(r_ir[15:12] - 4'd4);
            r_src <= r_ir[11:8];
            r_dst <= r_ir[3:0];
          end else if (r_ir[15:13] == 3'b001) begin
            r_cond <= r_ir[12:10];
            r_off  <= r_ir[OFFW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    instr_req = 1'b0;
    en_pc_2   = 1'b0;
    pc_inc    = 1'b0;
    branch_en = 1'b0;
    pc_offset = '0;
    wr_en     = 1'b0;
    illegal   = 1'b0;
    op_code   = r_op;
    src_reg   = r_src;
    dst_reg   = r_dst;
    wr_reg    = r_dst;
    unique case (r_state)
      S_FETCH:  instr_req = 1'b1;
      S_DECODE: begin
        en_pc_2 = 1'b1;
        pc_inc  = 1'b1;
        illegal = (r_ir[15:12] == 4'h0);
      end
      S_WB:     wr_en = 1'b1;
      S_BRANCH: begin
        if (w_taken) begin
          branch_en = 1'b1;
          pc_inc    = 1'b1;
          pc_offset = r_off;
        end
      end
      S_HALT: begin
        op_code = '0;
        src_reg = '0;
        dst_reg = '0;
        wr_reg  = '0;
      end
      default: ;
    endcase
  end

  assign fsm_state = r_state;
  assign fault     = r_fault;

endmodule

// File: tb/tb_control_unit_p.sv
// Self-checking bench for control_unit_p: directed test-plan cases plus random
// instruction streams checked against a per-instruction phase model.
module tb_control_unit_p;

  localparam int unsigned OPW       = 5;
  localparam int unsigned OFFW      = 10;
  localparam int unsigned STALL_MAX = 15;

  localparam logic [4:0] S_HLT = 5'b00000;
  localparam logic [4:0] S_FET = 5'b00001;
  localparam logic [4:0] S_DEC = 5'b00010;
  localparam logic [4:0] S_EXE = 5'b00100;
  localparam logic [4:0] S_WB  = 5'b01000;
  localparam logic [4:0] S_BR  = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, instr_valid;
  logic [15:0]     instruction;
  logic [3:0]      flags;
  logic            instr_req, en_pc_2, pc_inc, branch_en, wr_en, illegal, fault;
  logic [OFFW-1:0] pc_offset;
  logic [3:0]      src_reg, dst_reg, wr_reg;
  logic [OPW-1:0]  op_code;
  logic [4:0]      fsm_state;

  logic            rst1, valid1;
  logic [15:0]     instr1;
  logic            u1_req, u1_en2, u1_inc, u1_ben, u1_wren, u1_ill, u1_fault;
  logic [OFFW-1:0] u1_off;
  logic [3:0]      u1_src, u1_dst, u1_wr;
  logic [OPW-1:0]  u1_op;
  logic [4:0]      u1_state;

  int checks = 0;
  int errors = 0;

  control_unit_p #(.OPW(OPW), .OFFW(OFFW), .STALL_MAX(STALL_MAX), .WB_CMP_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid), .flags(flags),
    .instr_req(instr_req), .en_pc_2(en_pc_2), .pc_inc(pc_inc), .branch_en(branch_en),
    .pc_offset(pc_offset), .src_reg(src_reg), .dst_reg(dst_reg), .wr_reg(wr_reg),
    .wr_en(wr_en), .op_code(op_code), .fsm_state(fsm_state), .illegal(illegal), .fault(fault)
  );

  control_unit_p #(.OPW(OPW), .OFFW(OFFW), .STALL_MAX(STALL_MAX), .WB_CMP_BIT(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .instruction(instr1), .instr_valid(valid1), .flags(flags),
    .instr_req(u1_req), .en_pc_2(u1_en2), .pc_inc(u1_inc), .branch_en(u1_ben),
    .pc_offset(u1_off), .src_reg(u1_src), .dst_reg(u1_dst), .wr_reg(u1_wr),
    .wr_en(u1_wren), .op_code(u1_op), .fsm_state(u1_state), .illegal(u1_ill), .fault(u1_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Jump condition table with flags ordered {V,N,Z,C}
  function automatic bit jump_taken(input int cond, input logic [3:0] fl);
    bit v, n, z, c;
    v = fl[3]; n = fl[2]; z = fl[1]; c = fl[0];
    case (cond)
      0: return !z;
      1: return z;
      2: return !c;
      3: return c;
      4: return n;
      5: return n == v;
      6: return n != v;
      default: return 1'b1;
    endcase
  endfunction

  // Issue one instruction after 'stall' idle fetch cycles and check every phase.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, input int stall, input string tag);
    logic [4:0]     ph[$];
    int             nib;
    bit             tk;
    logic [5:0]     exp_ctl, act_ctl;
    logic [OPW-1:0] exp_op;
    nib    = int'(ir[15:12]);
    tk     = jump_taken(int'(ir[12:10]), fl);
    exp_op = OPW'(nib - 4);
    flags  = fl;
    ph.push_back(S_DEC);
    if (nib >= 4) begin
      ph.push_back(S_EXE);
      if (nib - 4 != 5 && nib - 4 != 7) ph.push_back(S_WB);
    end else if (nib >= 2) begin
      ph.push_back(S_BR);
    end
    for (int k = 0; k <= stall; k++) begin
      instr_valid = (k == stall);
      instruction = (k == stall) ? ir : 16'($urandom);
      checks++;
      if (fsm_state !== S_FET || instr_req !== 1'b1 || fault !== 1'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL %s fetch%0d: state=%b req=%b fault=%b wr_en=%b expected state=%b req=1 fault=0 wr_en=0",
                 tag, k, fsm_state, instr_req, fault, wr_en, S_FET);
      end
      step();
    end
    instr_valid = 1'b0;
    instruction = 16'($urandom);
    foreach (ph[i]) begin
      exp_ctl = '0;
      if (ph[i] == S_DEC) exp_ctl = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (nib == 0)};
      if (ph[i] == S_WB)  exp_ctl = 6'b000010;
      if (ph[i] == S_BR && tk) exp_ctl = 6'b001100;
      act_ctl = {instr_req, en_pc_2, pc_inc, branch_en, wr_en, illegal};
      checks++;
      if (fsm_state !== ph[i] || act_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s ir=%h phase%0d: state=%b ctl=%b expected state=%b ctl=%b",
                 tag, ir, i, fsm_state, act_ctl, ph[i], exp_ctl);
      end
      if (ph[i] == S_EXE || ph[i] == S_WB) begin
        checks++;
        if (op_code !== exp_op || src_reg !== ir[11:8] || dst_reg !== ir[3:0] || wr_reg !== ir[3:0]) begin
          errors++;
          $display("FAIL %s ir=%h regs: op=%h src=%h dst=%h wr=%h expected op=%h src=%h dst=%h wr=%h",
                   tag, ir, op_code, src_reg, dst_reg, wr_reg, exp_op, ir[11:8], ir[3:0], ir[3:0]);
        end
      end
      if (ph[i] == S_BR && tk) begin
        checks++;
        if (pc_offset !== ir[OFFW-1:0]) begin
          errors++;
          $display("FAIL %s ir=%h offset: got %h expected %h", tag, ir, pc_offset, ir[OFFW-1:0]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (fsm_state !== S_FET || {instr_req, en_pc_2, pc_inc, branch_en, wr_en, illegal, fault} !== 7'b1000000 ||
        op_code !== '0 || src_reg !== '0 || dst_reg !== '0 || wr_reg !== '0 || pc_offset !== '0) begin
      errors++;
      $display("FAIL reset: state=%b req=%b fault=%b op=%h src=%h dst=%h expected state=%b req=1 rest 0",
               fsm_state, instr_req, fault, op_code, src_reg, dst_reg, S_FET);
    end
    rst = 1'b1;
  endtask

  task automatic test_add();
    run_instr(16'h5203, 4'($urandom), 0, "add");
  endtask

  task automatic test_cmp();
    run_instr(16'h9105, 4'($urandom), 0, "cmp");
    run_instr(16'hB3A7, 4'($urandom), 1, "bit");
  endtask

  task automatic test_jumps();
    run_instr(16'h2412, 4'b0010, 0, "jeq_z1");
    run_instr(16'h2412, 4'b0000, 0, "jeq_z0");
    run_instr(16'h3C05, 4'($urandom), 0, "jmp");
    run_instr(16'h3805, 4'b1100, 0, "jl_nv");
  endtask

  task automatic test_illegal_nop();
    run_instr(16'h0ABC, 4'($urandom), 0, "illegal");
    run_instr(16'h1234, 4'($urandom), 0, "nop");
  endtask

  task automatic test_stall_boundary();
    run_instr(16'h4A1F, 4'($urandom), STALL_MAX - 1, "stall_edge");
  endtask

  task automatic test_random();
    for (int n = 0; n < 250; n++)
      run_instr(16'($urandom), 4'($urandom), int'($urandom_range(0, 3 * STALL_MAX / 4)), "rand");
  endtask

  task automatic test_fault();
    instr_valid = 1'b0;
    for (int k = 0; k < int'(STALL_MAX); k++) begin
      instruction = 16'($urandom);
      checks++;
      if (fsm_state !== S_FET || fault !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: state=%b fault=%b expected state=%b fault=0", k, fsm_state, fault, S_FET);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fsm_state !== S_HLT || fault !== 1'b1 ||
          {instr_req, en_pc_2, pc_inc, branch_en, wr_en, illegal} !== 6'b0 ||
          op_code !== '0 || src_reg !== '0 || dst_reg !== '0 || wr_reg !== '0 || pc_offset !== '0) begin
        errors++;
        $display("FAIL halt%0d: state=%b fault=%b req=%b wr_en=%b op=%h expected state=%b fault=1 all else 0",
                 k, fsm_state, fault, instr_req, wr_en, op_code, S_HLT);
      end
      instr_valid = 1'b1;
      step();
    end
    instr_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (fsm_state !== S_FET || fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: state=%b fault=%b expected state=%b fault=0", fsm_state, fault, S_FET);
    end
  endtask

  task automatic test_reset_mid();
    instruction = 16'h5203;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    checks++;
    if (fsm_state !== S_EXE) begin
      errors++;
      $display("FAIL mid_exec: state=%b expected %b", fsm_state, S_EXE);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fsm_state !== S_FET || wr_en !== 1'b0 || fault !== 1'b0 || op_code !== '0) begin
        errors++;
        $display("FAIL mid_reset%0d: state=%b wr_en=%b fault=%b op=%h expected state=%b wr_en=0 fault=0 op=0",
                 k, fsm_state, wr_en, fault, op_code, S_FET);
      end
      step();
    end
  endtask

  task automatic test_cmp_wb();
    logic [4:0] exp_st[4];
    exp_st = '{S_DEC, S_EXE, S_WB, S_FET};
    rst1 = 1'b0;
    step();
    step();
    rst1 = 1'b1;
    instr1 = 16'h9105;
    valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    instr1 = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (u1_state !== exp_st[k] || u1_wren !== (exp_st[k] == S_WB) ||
          ((exp_st[k] == S_EXE || exp_st[k] == S_WB) && (u1_op !== OPW'(5) || u1_wr !== 4'h5))) begin
        errors++;
        $display("FAIL cmp_wb%0d: state=%b wr_en=%b op=%h wr=%h expected state=%b wr_en=%b op=05 wr=5",
                 k, u1_state, u1_wren, u1_op, u1_wr, exp_st[k], (exp_st[k] == S_WB));
      end
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    rst1 = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    flags = '0;
    valid1 = 1'b0;
    instr1 = '0;
    test_reset();
    test_add();
    test_cmp();
    test_jumps();
    test_illegal_nop();
    test_stall_boundary();
    test_random();
    test_fault();
    test_reset_mid();
    test_cmp_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
